// File: rtl/stepper_pkg.sv
// ============================================================================
// Module  : stepper_pkg
// Brief   : Shared types and constants for the stepper phase sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package stepper_pkg;

    localparam int c_cnt_w_default = 16;
    localparam int c_pos_w_default = 32;

    // Entry n sits at bits [4n+3:4n], encoded as {AX,AY,BX,BY}
    localparam logic [31:0] c_phase_table = {
        4'b1001, 4'b0001, 4'b0101, 4'b0100,
        4'b0110, 4'b0010, 4'b1010, 4'b1000
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic [3:0] phase_lookup(input logic [2:0] idx);
        phase_lookup = c_phase_table[{idx, 2'b00} +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Generic two-flop synchroniser with a configurable reset value.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/step_motor_sequencer.sv
// ============================================================================
// Module  : step_motor_sequencer
// Brief   : Four-phase stepper coil sequencer with move commands, position
//           tracking and sticky driver-fault handling.
//           Optional macro STEP_IDLE_OFF_EN: de-energise coils after
//           IDLE_TIMEOUT idle clocks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module step_motor_sequencer
    import stepper_pkg::*;
#(
    parameter int CNT_W        = c_cnt_w_default,
    parameter int POS_W        = c_pos_w_default,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic             csi_MCLK_clk,
    input  logic             rsi_MCLK_reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             cmd_half,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             fault_n,
    input  logic             fault_clr,
    output logic             AX,
    output logic             AY,
    output logic             BX,
    output logic             BY,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [POS_W-1:0] position
);

    state_t r_state;
    state_t w_state_next;

    logic w_fault_n_sync;
    logic w_fault_s;
    logic w_handshake;
    logic w_step;
    logic w_finish;
    logic w_abort_take;
    logic w_period_hit;
    logic w_last_step;
    logic w_idle_off;

    logic [CNT_W-1:0] r_steps;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] w_cmd_period_eff;
    logic             r_dir;
    logic             r_half;
    logic             r_energised;
    logic             r_done_pend;
    logic             r_done;
    logic [2:0]       r_p;
    logic [2:0]       w_p_next;
    logic [POS_W-1:0] r_position;
    logic [POS_W-1:0] w_pos_next;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_fault_sync (
        .clk   (csi_MCLK_clk),
        .rst_n (rsi_MCLK_reset_n),
        .i_d   (fault_n),
        .o_q   (w_fault_n_sync)
    );

    assign w_fault_s        = ~w_fault_n_sync;
    assign w_cmd_period_eff = (cmd_period == '0) ? CNT_W'(1) : cmd_period;
    assign w_period_hit     = (r_per_cnt == r_period - CNT_W'(1));
    assign w_last_step      = (r_step_cnt + CNT_W'(1) == r_steps);

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MCLK_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority inside each state: fault, then abort, then step / handshake
    always_comb begin
        w_state_next = r_state;
        w_handshake  = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_abort_take = 1'b0;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        fault        = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = ~w_fault_s;
                if (w_fault_s) begin
                    w_state_next = FAULT;
                end else if (cmd_valid) begin
                    w_handshake  = 1'b1;
                    w_state_next = (cmd_steps == '0) ? IDLE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_fault_s) begin
                    w_state_next = FAULT;
                end else if (abort) begin
                    w_abort_take = 1'b1;
                    w_state_next = IDLE;
                end else if (w_period_hit) begin
                    w_step = 1'b1;
                    if (w_last_step) begin
                        w_finish     = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            FAULT: begin
                fault = 1'b1;
                if (!w_fault_s && fault_clr) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Full-step forces an odd index so two coils are always on together
    always_comb begin
        w_p_next   = r_p;
        w_pos_next = r_position;
        if (r_half) begin
            w_p_next   = r_dir ? r_p + 3'd1 : r_p - 3'd1;
            w_pos_next = r_dir ? r_position + POS_W'(1) : r_position - POS_W'(1);
        end else begin
            w_p_next   = (r_dir ? r_p + 3'd2 : r_p - 3'd2) | 3'd1;
            w_pos_next = r_dir ? r_position + POS_W'(2) : r_position - POS_W'(2);
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MCLK_reset_n) begin
            r_steps     <= '0;
            r_period    <= CNT_W'(1);
            r_per_cnt   <= '0;
            r_step_cnt  <= '0;
            r_dir       <= 1'b0;
            r_half      <= 1'b0;
            r_energised <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_p         <= 3'd0;
            r_position  <= '0;
        end else begin
            r_done_pend <= (w_handshake && (cmd_steps == '0)) || w_finish || w_abort_take;
            r_done      <= r_done_pend & ~w_fault_s;

            if (w_state_next == FAULT) begin
                r_energised <= 1'b0;
            end else if (w_handshake) begin
                r_energised <= 1'b1;
            end else if (w_idle_off) begin
                r_energised <= 1'b0;
            end

            if (w_handshake) begin
                r_steps    <= cmd_steps;
                r_period   <= w_cmd_period_eff;
                r_dir      <= cmd_dir;
                r_half     <= cmd_half;
                r_per_cnt  <= '0;
                r_step_cnt <= '0;
            end else if (w_step) begin
                r_per_cnt  <= '0;
                r_step_cnt <= r_step_cnt + CNT_W'(1);
                r_p        <= w_p_next;
                r_position <= w_pos_next;
            end else if (r_state == RUN) begin
                r_per_cnt  <= r_per_cnt + CNT_W'(1);
            end
        end
    end

`ifdef STEP_IDLE_OFF_EN
    localparam int c_idle_w = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_TIMEOUT - 1);

    logic [c_idle_w-1:0] r_idle_cnt;

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MCLK_reset_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state == IDLE) && r_energised && !w_handshake && !w_fault_s) begin
            r_idle_cnt <= w_idle_off ? '0 : r_idle_cnt + c_idle_w'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end

    assign w_idle_off = (r_state == IDLE) && r_energised && (r_idle_cnt == c_idle_last);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (IDLE_TIMEOUT != 0);
    assign w_idle_off       = 1'b0;
`endif

    assign {AX, AY, BX, BY} = r_energised ? phase_lookup(r_p) : 4'b0000;
    assign done             = r_done;
    assign position         = r_position;

endmodule

`default_nettype wire
